// File: rtl/axi4_lite_slave_regs.sv
// axi4_lite_slave_regs
// AXI4-Lite responder for a bank of NREGS 32-bit read/write control registers.
// Register contents are exported on REGS_OUT; WR_STROBE pulses for one cycle
// on the bit of each register that is written.
// Optional build macro AXI4_LITE_SLAVE_WSTRB_EN adds AXI_WSTRB byte-lane
// enables; without it every write replaces the full word.
//
// state  | meaning
// W_IDLE | collecting AW and W (either order); commits when both are held
// W_RESP | write committed, BVALID/BRESP held until BREADY
// R_IDLE | ARREADY high, waiting for a read address
// R_DATA | RVALID/RDATA/RRESP held until RREADY
module axi4_lite_slave_regs #(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int NREGS = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [AW-1:0]         AXI_AWADDR,
    input  logic                  AXI_AWVALID,
    output logic                  AXI_AWREADY,
    input  logic [DW-1:0]         AXI_WDATA,
`ifdef AXI4_LITE_SLAVE_WSTRB_EN
    input  logic [DW/8-1:0]       AXI_WSTRB,
`endif
    input  logic                  AXI_WVALID,
    output logic                  AXI_WREADY,
    output logic [1:0]            AXI_BRESP,
    output logic                  AXI_BVALID,
    input  logic                  AXI_BREADY,
    input  logic [AW-1:0]         AXI_ARADDR,
    input  logic                  AXI_ARVALID,
    output logic                  AXI_ARREADY,
    output logic [DW-1:0]         AXI_RDATA,
    output logic [1:0]            AXI_RRESP,
    output logic                  AXI_RVALID,
    input  logic                  AXI_RREADY,
    output logic [NREGS*DW-1:0]   REGS_OUT,
    output logic [NREGS-1:0]      WR_STROBE
);

    localparam int IW = $clog2(NREGS);
    localparam int SW = DW / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t          w_state_q, w_state_d;
    r_state_t          r_state_q, r_state_d;
    logic              aw_ready_q, aw_ready_d;
    logic              w_ready_q, w_ready_d;
    logic              aw_held_q, aw_held_d;
    logic              w_held_q, w_held_d;
    logic [AW-1:0]     awaddr_q, awaddr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [SW-1:0]     wstrb_q, wstrb_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [NREGS-1:0]  strobe_q, strobe_d;
    logic              ar_ready_q, ar_ready_d;
    logic              rvalid_q, rvalid_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [DW-1:0]     regs_q [NREGS];
    logic [DW-1:0]     regs_d [NREGS];

    logic              aw_hs, w_hs, ar_hs;
    logic [AW-1:0]     w_addr_eff;
    logic [DW-1:0]     wdata_eff;
    logic [SW-1:0]     wstrb_in, wstrb_eff;
    logic [IW-1:0]     w_idx, r_idx;
    logic              w_oob, r_oob;
    logic              unused_addr_lsbs;

`ifdef AXI4_LITE_SLAVE_WSTRB_EN
    assign wstrb_in = AXI_WSTRB;
`else
    assign wstrb_in = '1;
`endif

    // Handshakes and the effective write address/data, whether latched earlier or arriving now
    assign aw_hs      = AXI_AWVALID & aw_ready_q;
    assign w_hs       = AXI_WVALID & w_ready_q;
    assign ar_hs      = AXI_ARVALID & ar_ready_q;
    assign w_addr_eff = aw_hs ? AXI_AWADDR : awaddr_q;
    assign wdata_eff  = w_hs ? AXI_WDATA : wdata_q;
    assign wstrb_eff  = w_hs ? wstrb_in : wstrb_q;
    assign w_idx      = w_addr_eff[IW+1:2];
    assign w_oob      = |w_addr_eff[AW-1:IW+2];
    assign r_idx      = AXI_ARADDR[IW+1:2];
    assign r_oob      = |AXI_ARADDR[AW-1:IW+2];
    assign unused_addr_lsbs = ^{w_addr_eff[1:0], AXI_ARADDR[1:0]};

    // Write channel next-state: gather AW and W, commit once both are present
    always_comb begin
        w_state_d  = w_state_q;
        aw_ready_d = aw_ready_q;
        w_ready_d  = w_ready_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        strobe_d   = '0;
        regs_d     = regs_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    awaddr_d  = AXI_AWADDR;
                    aw_held_d = 1'b1;
                end
                if (w_hs) begin
                    wdata_d  = AXI_WDATA;
                    wstrb_d  = wstrb_in;
                    w_held_d = 1'b1;
                end
                if ((aw_held_q | aw_hs) && (w_held_q | w_hs)) begin
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    aw_ready_d = 1'b0;
                    w_ready_d  = 1'b0;
                    bvalid_d   = 1'b1;
                    bresp_d    = w_oob ? RESP_SLVERR : RESP_OKAY;
                    w_state_d  = W_RESP;
                    if (!w_oob) begin
                        strobe_d[w_idx] = 1'b1;
                        for (int b = 0; b < SW; b++) begin
                            if (wstrb_eff[b]) begin
                                regs_d[w_idx][b*8 +: 8] = wdata_eff[b*8 +: 8];
                            end
                        end
                    end
                end else begin
                    aw_ready_d = !(aw_held_q | aw_hs);
                    w_ready_d  = !(w_held_q | w_hs);
                end
            end
            W_RESP: begin
                if (AXI_BREADY) begin
                    bvalid_d   = 1'b0;
                    aw_ready_d = 1'b1;
                    w_ready_d  = 1'b1;
                    w_state_d  = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read channel next-state: capture register value on AR handshake, hold until RREADY
    always_comb begin
        r_state_d  = r_state_q;
        ar_ready_d = ar_ready_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                ar_ready_d = 1'b1;
                if (ar_hs) begin
                    ar_ready_d = 1'b0;
                    rvalid_d   = 1'b1;
                    rresp_d    = r_oob ? RESP_SLVERR : RESP_OKAY;
                    rdata_d    = r_oob ? '0 : regs_q[r_idx];
                    r_state_d  = R_DATA;
                end
            end
            R_DATA: begin
                if (AXI_RREADY) begin
                    rvalid_d   = 1'b0;
                    ar_ready_d = 1'b1;
                    r_state_d  = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            strobe_q   <= '0;
            ar_ready_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= 2'b00;
            rdata_q    <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            strobe_q   <= strobe_d;
            ar_ready_q <= ar_ready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign AXI_AWREADY = aw_ready_q;
    assign AXI_WREADY  = w_ready_q;
    assign AXI_BVALID  = bvalid_q;
    assign AXI_BRESP   = bresp_q;
    assign AXI_ARREADY = ar_ready_q;
    assign AXI_RVALID  = rvalid_q;
    assign AXI_RRESP   = rresp_q;
    assign AXI_RDATA   = rdata_q;
    assign WR_STROBE   = strobe_q;

    for (genvar i = 0; i < NREGS; i++) begin : g_regs_out
        assign REGS_OUT[i*DW +: DW] = regs_q[i];
    end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed testbench for axi4_lite_slave_regs (NREGS=8) with response scoreboards.
module tb_axi4_lite_slave_regs;

    localparam int NREGS = 8;
    localparam int IW    = 3;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic [31:0]         AXI_AWADDR = '0;
    logic                AXI_AWVALID = 1'b0;
    logic                AXI_AWREADY;
    logic [31:0]         AXI_WDATA = '0;
`ifdef AXI4_LITE_SLAVE_WSTRB_EN
    logic [3:0]          AXI_WSTRB = 4'hF;
`endif
    logic                AXI_WVALID = 1'b0;
    logic                AXI_WREADY;
    logic [1:0]          AXI_BRESP;
    logic                AXI_BVALID;
    logic                AXI_BREADY = 1'b0;
    logic [31:0]         AXI_ARADDR = '0;
    logic                AXI_ARVALID = 1'b0;
    logic                AXI_ARREADY;
    logic [31:0]         AXI_RDATA;
    logic [1:0]          AXI_RRESP;
    logic                AXI_RVALID;
    logic                AXI_RREADY = 1'b0;
    logic [NREGS*32-1:0] REGS_OUT;
    logic [NREGS-1:0]    WR_STROBE;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } rd_exp_t;

    rd_exp_t     rd_q[$];
    logic [1:0]  bresp_q[$];
    logic [31:0] exp_regs [NREGS];
    int          n_checks = 0;
    int          n_fail   = 0;

    axi4_lite_slave_regs #(.DW(32), .AW(32), .NREGS(NREGS)) dut (
        .clk(clk), .resetn(resetn),
        .AXI_AWADDR(AXI_AWADDR), .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
        .AXI_WDATA(AXI_WDATA),
`ifdef AXI4_LITE_SLAVE_WSTRB_EN
        .AXI_WSTRB(AXI_WSTRB),
`endif
        .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
        .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
        .AXI_ARADDR(AXI_ARADDR), .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
        .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RVALID(AXI_RVALID),
        .AXI_RREADY(AXI_RREADY),
        .REGS_OUT(REGS_OUT), .WR_STROBE(WR_STROBE)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic addr_ok(input logic [31:0] a);
        return a[31:IW+2] == '0;
    endfunction

    function automatic logic [255:0] model_flat();
        logic [255:0] f;
        for (int i = 0; i < NREGS; i++) f[i*32 +: 32] = exp_regs[i];
        return f;
    endfunction

    function automatic logic [7:0] exp_strobe(input logic [31:0] a);
        logic [7:0] s;
        s = '0;
        if (addr_ok(a)) s[a[IW+1:2]] = 1'b1;
        return s;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb);
        if (addr_ok(a)) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) exp_regs[a[IW+1:2]][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    task automatic push_read(input logic [31:0] a);
        rd_exp_t e;
        e.resp = addr_ok(a) ? 2'b00 : 2'b10;
        e.data = addr_ok(a) ? exp_regs[a[IW+1:2]] : 32'h0;
        rd_q.push_back(e);
    endtask

    task automatic pop_bresp(input string tag);
        check({tag, "_sb_nonempty"}, bresp_q.size() > 0, 1);
        if (bresp_q.size() > 0) check({tag, "_bresp"}, AXI_BRESP, bresp_q.pop_front());
    endtask

    task automatic pop_read(input string tag, output logic [31:0] held);
        rd_exp_t e;
        held = '0;
        check({tag, "_sb_nonempty"}, rd_q.size() > 0, 1);
        if (rd_q.size() > 0) begin
            e = rd_q.pop_front();
            held = e.data;
            check({tag, "_rdata"}, AXI_RDATA, e.data);
            check({tag, "_rresp"}, AXI_RRESP, e.resp);
        end
    endtask

    // AW and W issued together; BREADY held low for 'hold' cycles after the response appears
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb, input int hold);
        bit aw_hs, w_hs, aw_done, w_done;
        int n;
        bresp_q.push_back(addr_ok(a) ? 2'b00 : 2'b10);
        AXI_AWADDR = a; AXI_AWVALID = 1'b1;
        AXI_WDATA = d;  AXI_WVALID = 1'b1;
`ifdef AXI4_LITE_SLAVE_WSTRB_EN
        AXI_WSTRB = strb;
`endif
        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = AXI_AWVALID && AXI_AWREADY;
            w_hs  = AXI_WVALID && AXI_WREADY;
            tick();
            n++;
            if (aw_hs) begin aw_done = 1; AXI_AWVALID = 1'b0; end
            if (w_hs)  begin w_done = 1;  AXI_WVALID = 1'b0; end
        end
        AXI_AWVALID = 1'b0; AXI_WVALID = 1'b0;
        check("wr_handshake_in_budget", aw_done && w_done, 1);
        model_write(a, d, strb);
        check("wr_bvalid_at_commit", AXI_BVALID, 1);
        pop_bresp("wr");
        check("wr_strobe_pulse", WR_STROBE, exp_strobe(a));
        check("wr_regs_out", REGS_OUT, model_flat());
        for (int i = 0; i < hold; i++) begin
            tick();
            check("wr_bvalid_held", AXI_BVALID, 1);
            check("wr_no_accept_while_bvalid", {AXI_AWREADY, AXI_WREADY}, 2'b00);
        end
        AXI_BREADY = 1'b1;
        tick();
        AXI_BREADY = 1'b0;
        check("wr_bvalid_cleared", AXI_BVALID, 0);
        check("wr_ready_restored", {AXI_AWREADY, AXI_WREADY}, 2'b11);
        check("wr_strobe_one_cycle", WR_STROBE, 8'h00);
    endtask

    // Single read; RREADY held low for 'hold' cycles while data must stay stable
    task automatic axi_read(input logic [31:0] a, input int hold);
        bit ar_hs, done;
        int n;
        logic [31:0] held;
        push_read(a);
        AXI_ARADDR = a; AXI_ARVALID = 1'b1;
        done = 0; n = 0;
        while (!done && n < 20) begin
            ar_hs = AXI_ARVALID && AXI_ARREADY;
            tick();
            n++;
            if (ar_hs) begin done = 1; AXI_ARVALID = 1'b0; end
        end
        AXI_ARVALID = 1'b0;
        check("rd_handshake_in_budget", done, 1);
        check("rd_rvalid_next_cycle", AXI_RVALID, 1);
        pop_read("rd", held);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("rd_rdata_stable", {AXI_RVALID, AXI_ARREADY, AXI_RDATA}, {1'b1, 1'b0, held});
        end
        AXI_RREADY = 1'b1;
        tick();
        AXI_RREADY = 1'b0;
        check("rd_rvalid_cleared", {AXI_RVALID, AXI_ARREADY}, 2'b01);
    endtask

    // One channel first, the other 'gap' cycles later; intruding AW/W offered while BVALID is high
    task automatic ordered_write(input bit w_first, input logic [31:0] a, input logic [31:0] d, input int gap);
        bresp_q.push_back(addr_ok(a) ? 2'b00 : 2'b10);
        if (w_first) begin AXI_WDATA = d; AXI_WVALID = 1'b1; end
        else begin AXI_AWADDR = a; AXI_AWVALID = 1'b1; end
        tick();
        AXI_WVALID = 1'b0; AXI_AWVALID = 1'b0;
        check("ord_first_ready", {AXI_AWREADY, AXI_WREADY}, w_first ? 2'b10 : 2'b01);
        for (int i = 1; i < gap; i++) begin
            tick();
            check("ord_no_early_commit", {AXI_BVALID, WR_STROBE}, 9'h0);
        end
        if (w_first) begin AXI_AWADDR = a; AXI_AWVALID = 1'b1; end
        else begin AXI_WDATA = d; AXI_WVALID = 1'b1; end
        tick();
        AXI_WVALID = 1'b0; AXI_AWVALID = 1'b0;
        model_write(a, d, 4'hF);
        check("ord_bvalid_at_commit", AXI_BVALID, 1);
        pop_bresp("ord");
        check("ord_strobe", WR_STROBE, exp_strobe(a));
        check("ord_regs_out", REGS_OUT, model_flat());
        AXI_AWADDR = 32'h0; AXI_AWVALID = 1'b1;
        AXI_WDATA = 32'hBAD0_BAD0; AXI_WVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ord_blocked_while_bvalid", {AXI_BVALID, AXI_AWREADY, AXI_WREADY}, 3'b100);
        end
        AXI_AWVALID = 1'b0; AXI_WVALID = 1'b0;
        AXI_BREADY = 1'b1;
        tick();
        AXI_BREADY = 1'b0;
        check("ord_bvalid_cleared", AXI_BVALID, 0);
        check("ord_intruder_not_written", REGS_OUT, model_flat());
    endtask

    initial begin
        logic [31:0] held;
        for (int i = 0; i < NREGS; i++) exp_regs[i] = '0;

        // Reset: outputs quiet while resetn is low, READYs rise on the first released edge
        for (int i = 0; i < 4; i++) begin
            tick();
            check("reset_outputs_low",
                  {AXI_BVALID, AXI_RVALID, AXI_AWREADY, AXI_WREADY, AXI_ARREADY, AXI_BRESP, AXI_RRESP},
                  9'h0);
        end
        check("reset_rdata", AXI_RDATA, 32'h0);
        check("reset_regs_out", REGS_OUT, 256'h0);
        check("reset_strobe", WR_STROBE, 8'h00);
        resetn = 1'b1;
        tick();
        check("ready_after_reset", {AXI_AWREADY, AXI_WREADY, AXI_ARREADY}, 3'b111);

        for (int i = 0; i < NREGS; i++) axi_read(32'(i * 4), 0);

        // Basic write/readback to register 2
        axi_write(32'h08, 32'hDEAD_BEEF, 4'hF, 0);
        check("regs_out_reg2", REGS_OUT[95:64], 32'hDEAD_BEEF);
        axi_read(32'h08, 0);

        // Channel ordering, both directions
        ordered_write(1'b1, 32'h0C, 32'hA5A5_0003, 3);
        ordered_write(1'b0, 32'h10, 32'h5A5A_0004, 3);
        axi_read(32'h0C, 0);
        axi_read(32'h10, 0);

        // Out of range
        axi_write(32'h20, 32'h1234_5678, 4'hF, 2);
        axi_write(32'h8000_0008, 32'h1111_2222, 4'hF, 0);
        check("oob_reg2_untouched", REGS_OUT[95:64], 32'hDEAD_BEEF);
        axi_read(32'h20, 0);
        axi_read(32'h4000_0000, 0);
        axi_read(32'h0B, 0);

        // Concurrent write and read of register 1 on the same edge: read sees old value
        push_read(32'h04);
        bresp_q.push_back(2'b00);
        model_write(32'h04, 32'h55, 4'hF);
        AXI_AWADDR = 32'h04; AXI_AWVALID = 1'b1;
        AXI_WDATA = 32'h55;  AXI_WVALID = 1'b1;
        AXI_ARADDR = 32'h04; AXI_ARVALID = 1'b1;
`ifdef AXI4_LITE_SLAVE_WSTRB_EN
        AXI_WSTRB = 4'hF;
`endif
        tick();
        AXI_AWVALID = 1'b0; AXI_WVALID = 1'b0; AXI_ARVALID = 1'b0;
        check("conc_valids", {AXI_BVALID, AXI_RVALID}, 2'b11);
        check("conc_strobe", WR_STROBE, 8'b0000_0010);
        pop_bresp("conc");
        pop_read("conc", held);
        check("conc_old_value", held, 32'h0);
        AXI_BREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            AXI_BREADY = 1'b0;
            check("conc_rdata_stable", {AXI_RVALID, AXI_ARREADY, AXI_RDATA}, {1'b1, 1'b0, held});
        end
        check("conc_write_done", {AXI_BVALID, AXI_AWREADY, AXI_WREADY}, 3'b011);
        AXI_RREADY = 1'b1;
        tick();
        AXI_RREADY = 1'b0;
        check("conc_rvalid_cleared", {AXI_RVALID, AXI_ARREADY}, 2'b01);
        axi_read(32'h04, 0);
        check("conc_regs_out_reg1", REGS_OUT[63:32], 32'h55);

        // Back-to-back write with long response stall, then reads with RREADY stall
        axi_write(32'h1C, 32'hCAFE_F00D, 4'hF, 4);
        axi_read(32'h1C, 3);

`ifdef AXI4_LITE_SLAVE_WSTRB_EN
        axi_write(32'h00, 32'hFFFF_FFFF, 4'hF, 0);
        axi_write(32'h00, 32'h0000_0000, 4'b0101, 0);
        check("wstrb_reg0", REGS_OUT[31:0], 32'hFF00_FF00);
        axi_write(32'h00, 32'h0000_0000, 4'b0000, 0);
        axi_read(32'h00, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
